// File: rtl/pid_steering_if.sv
// Upstream/downstream signal bundle for pid_steering: error handshake, gains and steering command.
interface pid_steering_if #(
  parameter int DATA_W = 32,
  parameter int GAIN_W = 16,
  parameter int OUT_W  = 16
);
  logic signed [DATA_W-1:0] error;
  logic                     error_ready;
  logic                     enable;
  logic signed [GAIN_W-1:0] kp;
  logic signed [GAIN_W-1:0] ki;
  logic signed [GAIN_W-1:0] kd;
  logic signed [OUT_W-1:0]  control;
  logic                     control_valid;
  logic                     busy;

  modport master (
    output error, error_ready, enable, kp, ki, kd,
    input  control, control_valid, busy
  );

  modport slave (
    input  error, error_ready, enable, kp, ki, kd,
    output control, control_valid, busy
  );
endinterface

// File: rtl/pid_steering.sv
// Fixed-point PID steering law, one shared multiplier sequenced over MUL_P/MUL_I/MUL_D.
// Optional integrator anti-windup enabled by defining PID_ANTIWINDUP_EN.
module pid_steering #(
  parameter int DATA_W    = 32,
  parameter int GAIN_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int OUT_W     = 16,
  parameter int INT_LIMIT = 65536,
  parameter int OUT_MAX   = 1000,
  parameter int OUT_MIN   = -1000
) (
  input  logic          clk,
  input  logic          reset,
  pid_steering_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ACCUM, MUL_P, MUL_I, MUL_D, SUM} state_t;

  localparam logic signed [DATA_W:0]  INT_HI = (DATA_W+1)'(INT_LIMIT);
  localparam logic signed [DATA_W:0]  INT_LO = (DATA_W+1)'(-INT_LIMIT);
  localparam logic signed [63:0]      OMAX64 = 64'(OUT_MAX);
  localparam logic signed [63:0]      OMIN64 = 64'(OUT_MIN);
  localparam logic signed [OUT_W-1:0] OMAX_W = OUT_W'(OUT_MAX);
  localparam logic signed [OUT_W-1:0] OMIN_W = OUT_W'(OUT_MIN);

  state_t                   state_q, state_d;
  logic                     ready_q, trigger;
  logic signed [DATA_W-1:0] e_cur_q, e_prev_q, integ_q, integ_clamped;
  logic signed [DATA_W:0]   deriv_q, integ_sum, mul_x;
  logic                     first_q, hold_integ;
  logic signed [GAIN_W-1:0] mul_g;
  logic signed [63:0]       acc_q, g_ext, x_ext, prod, shifted;
  logic signed [OUT_W-1:0]  control_q, sat_val;
  logic                     valid_q;

  assign trigger = bus.error_ready & ~ready_q & bus.enable;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger) state_d = ACCUM;
      ACCUM:   state_d = MUL_P;
      MUL_P:   state_d = MUL_I;
      MUL_I:   state_d = MUL_D;
      MUL_D:   state_d = SUM;
      SUM:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy          = (state_q != IDLE);
    bus.control       = control_q;
    bus.control_valid = valid_q;
  end

  // Single multiplier: the state selects which gain/operand pair feeds it this cycle.
  always_comb begin
    mul_g = '0;
    mul_x = '0;
    case (state_q)
      MUL_P:   begin mul_g = bus.kp; mul_x = {e_cur_q[DATA_W-1], e_cur_q}; end
      MUL_I:   begin mul_g = bus.ki; mul_x = {integ_q[DATA_W-1], integ_q}; end
      MUL_D:   begin mul_g = bus.kd; mul_x = deriv_q; end
      default: ;
    endcase
  end

  assign g_ext = {{(64-GAIN_W){mul_g[GAIN_W-1]}}, mul_g};
  assign x_ext = {{(64-DATA_W-1){mul_x[DATA_W]}}, mul_x};
  assign prod  = g_ext * x_ext;

  always_comb begin
    integ_sum = {integ_q[DATA_W-1], integ_q} + {e_cur_q[DATA_W-1], e_cur_q};
    if (integ_sum > INT_HI)      integ_clamped = DATA_W'(INT_HI);
    else if (integ_sum < INT_LO) integ_clamped = DATA_W'(INT_LO);
    else                         integ_clamped = integ_sum[DATA_W-1:0];
`ifdef PID_ANTIWINDUP_EN
    hold_integ = ((control_q == OMAX_W) && !e_cur_q[DATA_W-1] && (|e_cur_q)) ||
                 ((control_q == OMIN_W) &&  e_cur_q[DATA_W-1]);
`else
    hold_integ = 1'b0;
`endif
  end

  // Saturate on the full-width shifted value before narrowing to OUT_W.
  always_comb begin
    shifted = acc_q >>> FRAC_BITS;
    if (shifted > OMAX64)      sat_val = OMAX_W;
    else if (shifted < OMIN64) sat_val = OMIN_W;
    else                       sat_val = shifted[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      e_cur_q   <= '0;
      e_prev_q  <= '0;
      integ_q   <= '0;
      deriv_q   <= '0;
      first_q   <= 1'b1;
      acc_q     <= '0;
      control_q <= '0;
    end else begin
      ready_q <= bus.error_ready;
      valid_q <= (state_q == SUM);
      case (state_q)
        IDLE: begin
          if (trigger) begin
            e_cur_q <= bus.error;
          end else if (!bus.enable) begin
            integ_q   <= '0;
            e_prev_q  <= '0;
            first_q   <= 1'b1;
            control_q <= '0;
          end
        end
        ACCUM: begin
          if (!hold_integ) integ_q <= integ_clamped;
          deriv_q  <= first_q ? '0 :
                      ({e_cur_q[DATA_W-1], e_cur_q} - {e_prev_q[DATA_W-1], e_prev_q});
          e_prev_q <= e_cur_q;
          first_q  <= 1'b0;
        end
        MUL_P:        acc_q <= prod;
        MUL_I, MUL_D: acc_q <= acc_q + prod;
        SUM:          control_q <= sat_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_steering.sv
// Directed self-checking bench for pid_steering; anti-windup scenario follows PID_ANTIWINDUP_EN.
module tb_pid_steering;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  pid_steering_if #(.DATA_W(32), .GAIN_W(16), .OUT_W(16)) bus ();

  pid_steering #(
    .DATA_W(32), .GAIN_W(16), .FRAC_BITS(8), .OUT_W(16),
    .INT_LIMIT(65536), .OUT_MAX(1000), .OUT_MIN(-1000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_gains(input logic signed [15:0] p, input logic signed [15:0] i,
                           input logic signed [15:0] d);
    @(negedge clk);
    bus.kp = p; bus.ki = i; bus.kd = d;
  endtask

  task automatic clear_ctrl();
    @(negedge clk);
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    bus.enable = 1'b1;
  endtask

  // Raise error_ready for one frame, wait (bounded) for control_valid, then drop the level.
  task automatic do_frame(input logic signed [31:0] err, output logic got, output int lat,
                          output logic signed [15:0] ctl);
    @(negedge clk);
    bus.error = err;
    bus.error_ready = 1'b1;
    @(posedge clk);
    got = 1'b0; lat = 0; ctl = '0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (bus.control_valid) begin got = 1'b1; lat = n; ctl = bus.control; end
    end
    bus.error_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.error = '0; bus.error_ready = 1'b0; bus.enable = 1'b1;
    bus.kp = '0; bus.ki = '0; bus.kd = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.control !== 16'sd0 || bus.control_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset: control=%0d valid=%b busy=%b, required 0/0/0",
               bus.control, bus.control_valid, bus.busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_proportional();
    set_gains(16'sd256, 16'sd0, 16'sd0);
    @(negedge clk);
    bus.error = 32'sd20;
    bus.error_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (bus.busy !== 1'b1 || bus.control_valid !== 1'b0) begin
        fails++;
        $display("FAIL prop_busy[k+%0d]: busy=%b valid=%b, required 1/0", i, bus.busy,
                 bus.control_valid);
      end
    end
    @(negedge clk);
    tests++;
    if (bus.control_valid !== 1'b1 || bus.control !== 16'sd20 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL prop_k5: valid=%b control=%0d busy=%b, required 1/20/0",
               bus.control_valid, bus.control, bus.busy);
    end
    @(negedge clk);
    tests++;
    if (bus.control_valid !== 1'b0 || bus.control !== 16'sd20) begin
      fails++;
      $display("FAIL prop_k6: valid=%b control=%0d, required 0/20", bus.control_valid, bus.control);
    end
    bus.error_ready = 1'b0;
  endtask

  task automatic test_saturation();
    logic signed [31:0] errs [3];
    logic signed [15:0] gains[3];
    logic signed [15:0] exps [3];
    logic got; int lat; logic signed [15:0] ctl;
    errs  = '{32'sd5000, -32'sd5000, -32'sd7};
    gains = '{16'sd256, 16'sd256, 16'sd128};
    exps  = '{16'sd1000, -16'sd1000, -16'sd4};
    for (int i = 0; i < 3; i++) begin
      set_gains(gains[i], 16'sd0, 16'sd0);
      do_frame(errs[i], got, lat, ctl);
      tests++;
      if (!got || lat != 6 || ctl !== exps[i]) begin
        fails++;
        $display("FAIL sat[%0d]: got=%b lat=%0d control=%0d, required 1/6/%0d",
                 i, got, lat, ctl, exps[i]);
      end
    end
  endtask

  task automatic test_enable_clear();
    clear_ctrl();
    tests++;
    if (bus.control !== 16'sd0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL enable_clear: control=%0d busy=%b, required 0/0", bus.control, bus.busy);
    end
  endtask

  task automatic test_integral();
    logic signed [31:0] errs [4];
    logic signed [15:0] exps [4];
    logic got; int lat; logic signed [15:0] ctl;
    errs = '{32'sd10, 32'sd10, 32'sd10, 32'sd100000};
    exps = '{16'sd10, 16'sd20, 16'sd30, 16'sd1000};
    clear_ctrl();
    set_gains(16'sd0, 16'sd256, 16'sd0);
    for (int i = 0; i < 4; i++) begin
      do_frame(errs[i], got, lat, ctl);
      tests++;
      if (!got || ctl !== exps[i]) begin
        fails++;
        $display("FAIL integ[%0d]: got=%b control=%0d, required 1/%0d", i, got, ctl, exps[i]);
      end
    end
    // integrator sits at +65536; error -65536 brings it to exactly 0
    do_frame(-32'sd65536, got, lat, ctl);
    tests++;
    if (!got || ctl !== 16'sd0) begin
      fails++;
      $display("FAIL integ_clamp: got=%b control=%0d, required 1/0", got, ctl);
    end
  endtask

  task automatic test_derivative();
    logic signed [31:0] errs [3];
    logic signed [15:0] exps [3];
    logic got; int lat; logic signed [15:0] ctl;
    errs = '{32'sd10, 32'sd30, 32'sd25};
    exps = '{16'sd0, 16'sd20, -16'sd5};
    clear_ctrl();
    set_gains(16'sd0, 16'sd0, 16'sd256);
    for (int i = 0; i < 3; i++) begin
      do_frame(errs[i], got, lat, ctl);
      tests++;
      if (!got || ctl !== exps[i]) begin
        fails++;
        $display("FAIL deriv[%0d]: got=%b control=%0d, required 1/%0d", i, got, ctl, exps[i]);
      end
    end
  endtask

  task automatic test_handshake();
    int pulses;
    logic got; int lat; logic signed [15:0] ctl;
    clear_ctrl();
    set_gains(16'sd256, 16'sd0, 16'sd0);
    @(negedge clk);
    bus.error = 32'sd42;
    bus.error_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.control_valid) pulses++;
    end
    tests++;
    if (pulses != 1 || bus.control !== 16'sd42) begin
      fails++;
      $display("FAIL hs_level: pulses=%0d control=%0d, required 1/42", pulses, bus.control);
    end
    @(negedge clk);
    bus.error_ready = 1'b0;
    @(negedge clk);
    bus.error = 32'sd50;
    bus.error_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.error_ready = 1'b0;
    @(negedge clk);
    bus.error = 32'sd77;
    bus.error_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.control_valid) pulses++;
    end
    tests++;
    if (pulses != 1 || bus.control !== 16'sd50) begin
      fails++;
      $display("FAIL hs_busy_drop: pulses=%0d control=%0d, required 1/50", pulses, bus.control);
    end
    @(negedge clk);
    bus.error_ready = 1'b0;
    do_frame(32'sd60, got, lat, ctl);
    tests++;
    if (!got || lat != 6 || ctl !== 16'sd60) begin
      fails++;
      $display("FAIL hs_rerise: got=%b lat=%0d control=%0d, required 1/6/60", got, lat, ctl);
    end
  endtask

  task automatic test_reset_midop();
    int pulses;
    logic got; int lat; logic signed [15:0] ctl;
    set_gains(16'sd0, 16'sd256, 16'sd0);
    @(negedge clk);
    bus.error = 32'sd99;
    bus.error_ready = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus.error_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.control_valid) pulses++;
    end
    tests++;
    if (pulses != 0 || bus.control !== 16'sd0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: pulses=%0d control=%0d busy=%b, required 0/0/0",
               pulses, bus.control, bus.busy);
    end
    do_frame(32'sd7, got, lat, ctl);
    tests++;
    if (!got || ctl !== 16'sd7) begin
      fails++;
      $display("FAIL rst_next: got=%b control=%0d, required 1/7", got, ctl);
    end
  endtask

  task automatic test_windup();
    logic signed [31:0] errs [6];
    logic signed [15:0] exps [6];
    logic got; int lat; logic signed [15:0] ctl;
    errs = '{32'sd2000, 32'sd2000, 32'sd2000, -32'sd500, -32'sd600, -32'sd5000};
`ifdef PID_ANTIWINDUP_EN
    exps = '{16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd900, -16'sd1000};
`else
    exps = '{16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, -16'sd100};
`endif
    clear_ctrl();
    set_gains(16'sd0, 16'sd256, 16'sd0);
    for (int i = 0; i < 6; i++) begin
      do_frame(errs[i], got, lat, ctl);
      tests++;
      if (!got || ctl !== exps[i]) begin
        fails++;
        $display("FAIL windup[%0d]: got=%b control=%0d, required 1/%0d", i, got, ctl, exps[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_proportional();
    test_saturation();
    test_enable_clear();
    test_integral();
    test_derivative();
    test_handshake();
    test_reset_midop();
    test_windup();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pid_steering.md
Name: pid_steering

Overview:
- Downstream stage of the mid-line error extractor in the line-following datapath.
- Consumes the signed per-frame centre-line error and its ready flag; produces one saturated steering command per frame via a fixed-point PID law.
- Uses a single shared multiplier sequenced by a small FSM, one product per cycle.
- Output feeds the motor/PWM mixing stage.

Parameters:
- DATA_W, 32, width of the signed error input.
- GAIN_W, 16, width of the signed kp/ki/kd inputs. Q(GAIN_W-FRAC_BITS).FRAC_BITS format.
- FRAC_BITS, 8, fractional bits of the gains. 256 = 1.0.
- OUT_W, 16, width of the signed control output.
- INT_LIMIT, 65536, symmetric clamp on the integrator: ±INT_LIMIT.
- OUT_MAX, 1000, upper saturation of control.
- OUT_MIN, -1000, lower saturation of control.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- error  in  DATA_W signed  centre-line error from the upstream stage.
- error_ready  in  1  upstream valid. This is a level that stays high until the next frame start.
- enable  in  1  controller run. When low, the controller holds its cleared state.
- kp  in  GAIN_W signed  proportional gain.
- ki  in  GAIN_W signed  integral gain.
- kd  in  GAIN_W signed  derivative gain.
- control  out  OUT_W signed  saturated steering command, held between updates.
- control_valid  out  1  one-cycle pulse when control updates.
- busy  out  1  high while the FSM is not IDLE.

Behaviour:
- Reset values: control=0, control_valid=0, busy=0. Internally: integrator=0, e_prev=0, first=1, state=IDLE, ready_q=0.
- Trigger: ready_q registers error_ready every cycle. The trigger is error_ready & ~ready_q & enable. A level held high yields exactly one trigger.
- FSM states: IDLE, ACCUM, MUL_P, MUL_I, MUL_D, SUM. Let k be the clock edge at which the trigger is sampled in IDLE:
  - edge k: e_cur<=error; state<=ACCUM.
  - edge k+1:
    - integ<=clamp(integ+e_cur, ±INT_LIMIT).
    - deriv<=first ? 0 : e_cur-e_prev.
    - e_prev<=e_cur; first<=0; state<=MUL_P.
  - edge k+2: acc<=kp*e_cur; state<=MUL_I.
  - edge k+3: acc<=acc+ki*integ; state<=MUL_D.
  - edge k+4: acc<=acc+kd*deriv; state<=SUM.
  - edge k+5: control<=sat(acc>>>FRAC_BITS, OUT_MIN, OUT_MAX); control_valid<=1; state<=IDLE.
  - edge k+6: control_valid<=0.
- Latency is 5 clocks from trigger to control_valid. Minimum trigger spacing is 6 cycles.
- Arithmetic:
  - acc is signed 64-bit; all products are sign-extended to 64 bits.
  - >>> is an arithmetic shift (floor).
  - deriv is DATA_W+1 bits; integ is DATA_W bits.
  - Saturation is applied after the shift and before truncation to OUT_W.
- Triggers while busy are dropped (no queueing). error is sampled only at edge k.
- enable low:
  - In IDLE: integ=0, e_prev=0, first=1, control=0; no control_valid.
  - Mid-sequence: the sequence completes normally, then state is cleared on return to IDLE.
- reset at any edge, including mid-sequence: immediately returns to the reset values. No control_valid for the aborted frame.
- Gains are sampled live in MUL_P, MUL_I and MUL_D respectively. Gains must be held stable per frame.

Optional Feature:
- Macro: PID_ANTIWINDUP_EN.
- Defined:
  - At edge k+1 the integrator update is skipped when the previous control==OUT_MAX and e_cur>0.
  - It is also skipped when the previous control==OUT_MIN and e_cur<0.
  - Otherwise it is updated as normal (still clamped).
- Undefined: the integrator is always updated and only the ±INT_LIMIT clamp applies.

Test Plan:
1. Proportional: kp=256, ki=kd=0, enable=1, error=20, error_ready 0->1 at edge k -> control=20 and control_valid high for exactly one cycle at edge k+5; busy high edges k..k+4.
2. Saturation: kp=256, error=5000 -> control=1000. error=-5000 on the next frame -> control=-1000.
3. Integral: ki=256, kp=kd=0; three frames with error=10 -> 10, 20, 30. Then error=100000 -> integ clamps to 65536 and control=1000.
4. Derivative: kd=256, kp=ki=0. Frame 1 error=10 -> 0 (first-sample rule). Frame 2 error=30 -> 20. Frame 3 error=25 -> -5.
5. Handshake: error_ready held high 500 cycles -> one control_valid. Drop to 0 and re-rise at k+2 -> no second pulse. Re-rise after k+6 -> new pulse.
6. Reset mid-op: trigger at k, reset at k+3 -> no control_valid, control=0. The next frame with ki=256, error=7 -> control=7 (integrator cleared).
7. Anti-windup (PID_ANTIWINDUP_EN only): ki=256, error=2000 repeated -> control stays at 1000 and integ stays 2000. Then error=-500 -> control=1500 saturates to 1000, integ decrements to 1500.
